// File: rtl/burst_trig_receiver_if.sv
// Signal bundle between the trigger source / waveform engine
// and the burst trigger receiver.
interface burst_trig_receiver_if #(
    parameter int AMT_W = 20,
    parameter int DLY_W = 34
);
    logic             Trig_Sin;
    logic             Edge_Sel;
    logic             Burst_EN;
    logic [DLY_W-1:0] Delay_ValueIN;
    logic [AMT_W-1:0] Amount_IN;
    logic             Cycle_End;
    logic             Gate_Out;
    logic             Busy;
    logic             Burst_Done;
    logic             Trig_Miss;
    logic [AMT_W-1:0] Cycle_Cnt;

    modport master (
        output Trig_Sin, Edge_Sel, Burst_EN,
        output Delay_ValueIN, Amount_IN, Cycle_End,
        input  Gate_Out, Busy, Burst_Done, Trig_Miss, Cycle_Cnt
    );

    modport slave (
        input  Trig_Sin, Edge_Sel, Burst_EN,
        input  Delay_ValueIN, Amount_IN, Cycle_End,
        output Gate_Out, Busy, Burst_Done, Trig_Miss, Cycle_Cnt
    );
endinterface

// File: rtl/burst_trig_receiver.sv
// Burst trigger receiver: synchronised edge trigger, optional
// start delay, then a gate held for a counted number of cycles.
module burst_trig_receiver #(
    parameter int AMT_W = 20,
    parameter int DLY_W = 34
) (
    input logic                  Clock,
    input logic                  Reset,
    burst_trig_receiver_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic             trig_p_q, trig_p_d;
    logic             trig_miss_q, trig_miss_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [AMT_W-1:0] cnt_inc;

    // Two-flop synchroniser plus history flop; edge pulse is registered
    always_comb begin
        sync_d   = {sync_q[1], sync_q[0], bus.Trig_Sin};
        trig_p_d = bus.Edge_Sel ? (~sync_q[1] & sync_q[2])
                                : (sync_q[1] & ~sync_q[2]);
    end

    // Burst sequencing, latching of parameters and cycle counting
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        amt_d       = amt_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + AMT_W'(1);
        trig_miss_d = trig_p_q & ~((state_q == IDLE) & bus.Burst_EN);
        unique case (state_q)
            IDLE: begin
                if (trig_p_q && bus.Burst_EN) begin
                    dly_d   = bus.Delay_ValueIN;
                    amt_d   = bus.Amount_IN;
                    cnt_d   = '0;
                    state_d = (bus.Delay_ValueIN == '0) ? RUN : DELAY;
                end
            end
            DELAY: begin
                if (!bus.Burst_EN) begin
                    state_d = IDLE;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                    if (dly_q == DLY_W'(1)) state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.Burst_EN) begin
                    state_d = IDLE;
                end else if (bus.Cycle_End) begin
                    cnt_d = cnt_inc;
                    if (amt_q != '0 && cnt_inc == amt_q) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            trig_p_q    <= 1'b0;
            trig_miss_q <= 1'b0;
            dly_q       <= '0;
            amt_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            trig_p_q    <= trig_p_d;
            trig_miss_q <= trig_miss_d;
            dly_q       <= dly_d;
            amt_q       <= amt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.Gate_Out   = (state_q == RUN);
    assign bus.Busy       = (state_q != IDLE);
    assign bus.Burst_Done = (state_q == DONE);
    assign bus.Trig_Miss  = trig_miss_q;
    assign bus.Cycle_Cnt  = cnt_q;
endmodule

// File: doc/burst_trig_receiver.md
BURST_TRIG_RECEIVER -- requirements
Module: burst_trig_receiver

Interface
REQ-001 Parameter AMT_W, default 20: width of burst cycle amount and cycle counter.
REQ-002 Parameter DLY_W, default 34: width of trigger delay value, in Clock cycles.
REQ-003 Port Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port Reset  input  1  asynchronous, active-high reset.
REQ-005 Port Trig_Sin  input  1  external/manual trigger; asynchronous to Clock.
REQ-006 Port Edge_Sel  input  1  active trigger edge: 0 = rising, 1 = falling.
REQ-007 Port Burst_EN  input  1  burst mode enable; low forces idle.
REQ-008 Port Delay_ValueIN  input  DLY_W  trigger-to-gate delay in Clock cycles.
REQ-009 Port Amount_IN  input  AMT_W  waveform cycles per burst; 0 = infinite burst.
REQ-010 Port Cycle_End  input  1  one-Clock pulse from waveform engine at each cycle end.
REQ-011 Port Gate_Out  output  1  burst gate to waveform engine; high while burst runs.
REQ-012 Port Busy  output  1  high in any state other than IDLE.
REQ-013 Port Burst_Done  output  1  one-Clock pulse at normal burst completion.
REQ-014 Port Trig_Miss  output  1  one-Clock pulse when a trigger is rejected.
REQ-015 Port Cycle_Cnt  output  AMT_W  completed cycles in the current burst.

Function
REQ-016 Trig_Sin SHALL pass through a 2-flop synchronizer, then a registered edge detector per Edge_Sel, producing internal pulse trig_p exactly 3 Clock edges after the input transition.
REQ-017 FSM states SHALL be IDLE, DELAY, RUN, DONE; encoding free.
REQ-018 IDLE + trig_p + Burst_EN=1: latch Delay_ValueIN and Amount_IN, clear Cycle_Cnt; go RUN if latched delay = 0, else DELAY.
REQ-019 DELAY: count latched delay down; enter RUN so Gate_Out rises exactly D Clock cycles later than with delay 0.
REQ-020 Gate_Out SHALL be high exactly while state = RUN (registered output, no combinational path from inputs).
REQ-021 RUN + Cycle_End: Cycle_Cnt increments by 1, modulo 2^AMT_W.
REQ-022 RUN + Cycle_End where Cycle_Cnt+1 = latched amount (amount != 0): go DONE; Gate_Out low on that same edge.
REQ-023 DONE SHALL last exactly one Clock, assert Burst_Done during it, then return to IDLE.
REQ-024 Latched amount 0: RUN persists until Burst_EN falls; Cycle_Cnt wraps freely.
REQ-025 Burst_EN low in any state: IDLE on the next edge, Gate_Out low, no Burst_Done; Cycle_Cnt holds.
REQ-026 trig_p in DELAY, RUN or DONE, or in IDLE with Burst_EN=0: Trig_Miss pulses one Clock; state, counters and latched values unaffected.
REQ-027 Cycle_End outside RUN SHALL be ignored.
REQ-028 Changes on Delay_ValueIN/Amount_IN after acceptance SHALL NOT affect the burst in progress.
REQ-029 Busy SHALL be high in DELAY, RUN, DONE.

Reset
REQ-030 Reset high SHALL immediately force IDLE, Gate_Out=0, Busy=0, Burst_Done=0, Trig_Miss=0, Cycle_Cnt=0, delay counter=0, synchronizer and edge flops=0.
REQ-031 Reset asserted mid-burst SHALL abort with no Burst_Done; after release a fresh edge (relative to the reset synchronizer value) is needed to start.

Verification
REQ-032 Edge_Sel=0, Delay=0, Amount=3, Burst_EN=1, Trig_Sin rises, 3 Cycle_End pulses -> Gate_Out high from 4th edge, low on 3rd Cycle_End edge, Burst_Done one pulse, Cycle_Cnt=3.
REQ-033 Delay=5, Amount=1 -> Gate_Out rises exactly 5 Clocks later than REQ-032 case; Busy high from acceptance to DONE.
REQ-034 Edge_Sel=1, rising edge only -> no start; falling edge -> start as REQ-032.
REQ-035 Second trigger during RUN and trigger with Burst_EN=0 -> Trig_Miss pulse each, burst unaffected, Cycle_Cnt unchanged.
REQ-036 Amount=0, 2^AMT_W+2 Cycle_End pulses, then Burst_EN low -> Cycle_Cnt=2, Gate_Out low next edge, no Burst_Done.
REQ-037 Reset pulse during RUN at Cycle_Cnt=7 -> all outputs 0 immediately, Cycle_Cnt=0, no Burst_Done.
